// File: rtl/kernel_convolve_3x3.sv
`default_nettype none
// ============================================================================
// Module      : kernel_convolve_3x3
// Description : Builds a 3x3 window from a 3-row column stream and convolves
//               each RGB565 channel with a frame-latched signed 3x3 kernel.
//               The shifted sums are reduced back to 5/6/5 bits and packed.
//               Define SATURATE_EN to clamp each channel to its range. When it
//               is not defined, the low channel bits are kept and values wrap.
//               Latency is 4 cycles. Throughput is one pixel per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_convolve_3x3 #(
    parameter int HRES = 1280,
    parameter int VRES = 720
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [2:0][15:0]         data_in,
    input  logic [$clog2(HRES)-1:0]  hcount_in,
    input  logic [$clog2(VRES)-1:0]  vcount_in,
    input  logic                     data_valid_in,
    input  logic [8:0][7:0]          coeff_in,
    input  logic [3:0]               shift_in,
    output logic [15:0]              pixel_out,
    output logic [$clog2(HRES)-1:0]  hcount_out,
    output logic [$clog2(VRES)-1:0]  vcount_out,
    output logic                     data_valid_out
);

    localparam int HW = $clog2(HRES);
    localparam int VW = $clog2(VRES);

    // Frame-latched kernel. The shift is carried alongside the data so that
    // pixels still in flight from the previous frame keep their own shift.
    logic [8:0][7:0]      r_coeff;
    logic [3:0]           r_shift;
    logic [3:0]           r_shift_s2;
    logic [3:0]           r_shift_s3;

    // Window columns: r_win[0] is the oldest (left), r_win[2] the newest.
    logic [2:0][15:0]     r_win [3];

    logic [5:0]           w_px   [9][3];
    logic signed [14:0]   w_prod [3][9];
    logic signed [14:0]   r_prod [3][9];
    logic signed [18:0]   w_sum  [3];
    logic signed [18:0]   r_sum  [3];
    logic signed [18:0]   w_shift[3];
    logic [5:0]           w_chan [3];
    logic [15:0]          w_pix;
    logic [15:0]          r_pix;
    logic                 w_unused;

    logic                 w_emit;
    logic                 w_frame_start;
    logic [3:0]           r_vld;
    logic [HW-1:0]        r_hc [4];
    logic [VW-1:0]        r_vc [4];

    assign w_frame_start = data_valid_in && (hcount_in == '0) && (vcount_in == '0);
    assign w_emit        = data_valid_in && (hcount_in >= HW'(2));

    // Capture kernel and shift on the first valid pixel of each frame.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_coeff <= '0;
            r_shift <= '0;
        end else if (w_frame_start) begin
            r_coeff <= coeff_in;
            r_shift <= shift_in;
        end
    end

    // S1: the window advances only on valid columns, so gaps leave it intact.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_win <= '{default: '0};
        end else if (data_valid_in) begin
            r_win[0] <= r_win[1];
            r_win[1] <= r_win[2];
            r_win[2] <= data_in;
        end
    end

    // Split each window tap into zero-extended channels. Tap t sits at row
    // t/3 and column t%3. One signed product is formed per tap and channel.
    for (genvar t = 0; t < 9; t++) begin : g_tap
        assign w_px[t][0] = {1'b0, r_win[t % 3][t / 3][15:11]};
        assign w_px[t][1] = r_win[t % 3][t / 3][10:5];
        assign w_px[t][2] = {1'b0, r_win[t % 3][t / 3][4:0]};
        for (genvar ch = 0; ch < 3; ch++) begin : g_mul
            assign w_prod[ch][t] = $signed(r_coeff[t]) * $signed({1'b0, w_px[t][ch]});
        end
    end

    // S2: register the products and the shift that belongs with them.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_prod     <= '{default: '0};
            r_shift_s2 <= '0;
        end else begin
            r_prod     <= w_prod;
            r_shift_s2 <= r_shift;
        end
    end

    // Sum the nine products and reduce each channel to its field width.
    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        assign w_sum[ch] = 19'(r_prod[ch][0]) + 19'(r_prod[ch][1]) + 19'(r_prod[ch][2])
                         + 19'(r_prod[ch][3]) + 19'(r_prod[ch][4]) + 19'(r_prod[ch][5])
                         + 19'(r_prod[ch][6]) + 19'(r_prod[ch][7]) + 19'(r_prod[ch][8]);
        assign w_shift[ch] = r_sum[ch] >>> r_shift_s3;
`ifdef SATURATE_EN
        localparam logic signed [18:0] c_MAX = (ch == 1) ? 19'sd63 : 19'sd31;
        assign w_chan[ch] = w_shift[ch][18]        ? 6'd0 :
                            (w_shift[ch] > c_MAX)  ? c_MAX[5:0] :
                                                     w_shift[ch][5:0];
`else
        assign w_chan[ch] = (ch == 1) ? w_shift[ch][5:0] : {1'b0, w_shift[ch][4:0]};
`endif
    end

`ifdef SATURATE_EN
    assign w_unused = ^{w_chan[0][5], w_chan[2][5]};
`else
    assign w_unused = ^{w_shift[0], w_shift[1], w_shift[2], w_chan[0][5], w_chan[2][5]};
`endif

    assign w_pix = {w_chan[0][4:0], w_chan[1], w_chan[2][4:0]};

    // S3/S4: register the channel sums, then register the packed pixel.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_sum      <= '{default: '0};
            r_shift_s3 <= '0;
            r_pix      <= '0;
        end else begin
            r_sum      <= w_sum;
            r_shift_s3 <= r_shift_s2;
            r_pix      <= w_pix;
        end
    end

    // Carry valid and the centre coordinates alongside the four data stages.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_vld <= '0;
            r_hc  <= '{default: '0};
            r_vc  <= '{default: '0};
        end else begin
            r_vld <= {r_vld[2:0], w_emit};
            r_hc[0] <= hcount_in - HW'(1);
            r_vc[0] <= vcount_in;
            r_hc[1] <= r_hc[0];
            r_vc[1] <= r_vc[0];
            r_hc[2] <= r_hc[1];
            r_vc[2] <= r_vc[1];
            r_hc[3] <= r_hc[2];
            r_vc[3] <= r_vc[2];
        end
    end

    assign pixel_out      = r_pix;
    assign hcount_out     = r_hc[3];
    assign vcount_out     = r_vc[3];
    assign data_valid_out = r_vld[3];

endmodule
`default_nettype wire

// File: tb/tb_kernel_convolve_3x3.sv
`default_nettype none
// ============================================================================
// Module      : tb_kernel_convolve_3x3
// Description : Self-checking bench for kernel_convolve_3x3. It holds an
//               integer reference model and checks the outputs every cycle.
//               Hand-computed pixel values pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kernel_convolve_3x3;

    localparam int DEPTH = 4096;

    logic             clk = 1'b0;
    logic             rst_in;
    logic [2:0][15:0] data_in;
    logic [10:0]      hcount_in;
    logic [9:0]       vcount_in;
    logic             data_valid_in;
    logic [8:0][7:0]  coeff_in;
    logic [3:0]       shift_in;
    logic [15:0]      pixel_out;
    logic [10:0]      hcount_out;
    logic [9:0]       vcount_out;
    logic             data_valid_out;

    kernel_convolve_3x3 dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .data_in        (data_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .data_valid_in  (data_valid_in),
        .coeff_in       (coeff_in),
        .shift_in       (shift_in),
        .pixel_out      (pixel_out),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .data_valid_out (data_valid_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    // Expected outputs, indexed by the cycle in which they must be visible.
    bit          exp_valid [DEPTH];
    logic [15:0] exp_pix   [DEPTH];
    logic [10:0] exp_h     [DEPTH];
    logic [9:0]  exp_vc    [DEPTH];

    // Reference model state.
    logic [2:0][15:0] mw [3];
    logic [8:0][7:0]  m_coeff;
    int               m_shift;

    logic [15:0] last_pix;
    logic [10:0] last_h;
    logic [9:0]  last_v;
    int          n_seen = 0;
    int          rec_sel = 0;
    logic [36:0] qa [$];
    logic [36:0] qb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int chan_of(input logic [15:0] p, input int ch);
        if (ch == 0) return (int'(p) >> 11) & 31;
        if (ch == 1) return (int'(p) >> 5) & 63;
        return int'(p) & 31;
    endfunction

    // Convolution of the model window with the latched kernel, in plain integers.
    function automatic logic [15:0] model_pixel();
        int res [3];
        for (int ch = 0; ch < 3; ch++) begin
            int sum;
            int s;
            int mx;
            sum = 0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    sum += int'($signed(m_coeff[3*r+c])) * chan_of(mw[c][r], ch);
            s  = sum >>> m_shift;
            mx = (ch == 1) ? 63 : 31;
`ifdef SATURATE_EN
            res[ch] = (s < 0) ? 0 : (s > mx) ? mx : s;
`else
            res[ch] = s & mx;
`endif
        end
        return 16'((res[0] << 11) | (res[1] << 5) | res[2]);
    endfunction

    function automatic logic [15:0] gen(input int kind, input int h, input int v, input int r);
        case (kind)
            0:       return 16'(h*37 + r*1000 + v*7);
            1:       return 16'hFFFF;
            2:       return 16'h8410;
            default: return (h == 2 && r == 1) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    task automatic send(input int h, input int v, input int kind);
        logic [2:0][15:0] d;
        for (int r = 0; r < 3; r++) d[r] = gen(kind, h, v, r);
        @(negedge clk);
        data_valid_in = 1'b1;
        hcount_in     = 11'(h);
        vcount_in     = 10'(v);
        data_in       = d;
        if (h == 0 && v == 0) begin
            m_coeff = coeff_in;
            m_shift = int'(shift_in);
        end
        mw[0] = mw[1];
        mw[1] = mw[2];
        mw[2] = d;
        if (h >= 2 && cyc + 4 < DEPTH) begin
            exp_valid[cyc+4] = 1'b1;
            exp_pix[cyc+4]   = model_pixel();
            exp_h[cyc+4]     = 11'(h - 1);
            exp_vc[cyc+4]    = 10'(v);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            data_valid_in = 1'b0;
            hcount_in     = 11'($urandom_range(1279));
            vcount_in     = 10'($urandom_range(719));
            data_in       = {16'($urandom), 16'($urandom), 16'($urandom)};
        end
    endtask

    task automatic line(input int v, input int h0, input int n, input int kind, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(1) == 0) idle(1);
            end
            send((h0 + i) % 1280, v, kind);
        end
    endtask

    task automatic set_kernel(input int k0, input int k1, input int k2, input int k3, input int k4,
                              input int k5, input int k6, input int k7, input int k8, input int sh);
        coeff_in[0] = 8'(k0); coeff_in[1] = 8'(k1); coeff_in[2] = 8'(k2);
        coeff_in[3] = 8'(k3); coeff_in[4] = 8'(k4); coeff_in[5] = 8'(k5);
        coeff_in[6] = 8'(k6); coeff_in[7] = 8'(k7); coeff_in[8] = 8'(k8);
        shift_in    = 4'(sh);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cyc < DEPTH) begin
            chk("valid_out", 32'(data_valid_out), 32'(exp_valid[cyc]));
            if (exp_valid[cyc]) begin
                chk("pixel_out", 32'(pixel_out), 32'(exp_pix[cyc]));
                chk("hcount_out", 32'(hcount_out), 32'(exp_h[cyc]));
                chk("vcount_out", 32'(vcount_out), 32'(exp_vc[cyc]));
            end
        end
        if (data_valid_out) begin
            last_pix <= pixel_out;
            last_h   <= hcount_out;
            last_v   <= vcount_out;
            n_seen   <= n_seen + 1;
            if (rec_sel == 1) qa.push_back({pixel_out, hcount_out, vcount_out});
            if (rec_sel == 2) qb.push_back({pixel_out, hcount_out, vcount_out});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen0;
        for (int i = 0; i < DEPTH; i++) exp_valid[i] = 1'b0;
        mw       = '{default: '0};
        m_coeff  = '0;
        m_shift  = 0;
        rst_in        = 1'b1;
        data_valid_in = 1'b0;
        data_in       = '0;
        hcount_in     = '0;
        vcount_in     = '0;
        coeff_in      = '0;
        shift_in      = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(data_valid_out), 32'd0);
        chk("rst_pixel", 32'(pixel_out), 32'd0);
        chk("rst_hcount", 32'(hcount_out), 32'd0);
        chk("rst_vcount", 32'(vcount_out), 32'd0);
        @(posedge clk); #2 rst_in = 1'b0;

        // Identity kernel on a ramp, including a line wrap 1279 -> 0
        set_kernel(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        line(0, 0, 10, 0, 1'b0);
        idle(6);
        chk("ident_pix", 32'(last_pix), 32'h0510);
        chk("ident_h", 32'(last_h), 32'd8);
        line(1, 1276, 4, 0, 1'b0);
        line(2, 0, 5, 0, 1'b0);
        idle(6);
        chk("wrap_pix", 32'(last_pix), 32'h0465);
        chk("wrap_h", 32'(last_h), 32'd3);
        chk("wrap_v", 32'(last_v), 32'd2);

        // Box kernel, shift 3, white field
        set_kernel(1, 1, 1, 1, 1, 1, 1, 1, 1, 3);
        line(0, 0, 6, 1, 1'b0);
        idle(6);
`ifdef SATURATE_EN
        chk("box_pix", 32'(last_pix), 32'hFFFF);
`else
        chk("box_pix", 32'(last_pix), 32'h10C2);
`endif

        // Laplacian: flat field, then a single bright centre pixel
        set_kernel(-1, -1, -1, -1, 8, -1, -1, -1, -1, 0);
        line(0, 0, 6, 2, 1'b0);
        idle(6);
        chk("lap_flat", 32'(last_pix), 32'h0000);
        line(5, 0, 4, 3, 1'b0);
        idle(6);
`ifdef SATURATE_EN
        chk("lap_bright", 32'(last_pix), 32'hFFFF);
`else
        chk("lap_bright", 32'(last_pix), 32'hC718);
`endif

        // Kernel change mid-frame is ignored until the next frame start
        set_kernel(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        line(6, 0, 6, 2, 1'b0);
        idle(6);
        chk("midframe_hold", 32'(last_pix), 32'h0000);
        line(0, 0, 6, 2, 1'b0);
        idle(6);
        chk("newframe_apply", 32'(last_pix), 32'h8410);

        // Contiguous vs gapped stream with a mixed kernel
        set_kernel(-2, 3, -1, 4, 5, -3, 1, -1, 2, 1);
        line(0, 0, 3, 0, 1'b0);
        idle(6);
        rec_sel = 1;
        line(1, 0, 12, 0, 1'b0);
        idle(6);
        rec_sel = 2;
        line(1, 0, 12, 0, 1'b1);
        idle(6);
        rec_sel = 0;
        chk("gap_count_a", 32'(qa.size()), 32'd10);
        chk("gap_count_b", 32'(qb.size()), 32'd10);
        if (qa.size() == qb.size()) begin
            for (int i = 0; i < qa.size(); i++) chk("gap_seq", 32'(qb[i][36:21]) ^ 32'(qb[i][20:0] != qa[i][20:0]) << 20,
                                                    32'(qa[i][36:21]));
        end

        // Asynchronous reset mid-line
        set_kernel(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        line(3, 0, 6, 0, 1'b0);
        @(posedge clk);
        #2 rst_in = 1'b1;
        data_valid_in = 1'b0;
        for (int i = cyc; i < DEPTH; i++) exp_valid[i] = 1'b0;
        mw      = '{default: '0};
        m_coeff = '0;
        m_shift = 0;
        #1 chk("rst_async_valid", 32'(data_valid_out), 32'd0);
        chk("rst_async_pixel", 32'(pixel_out), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #2 rst_in = 1'b0;
        seen0 = n_seen;
        line(0, 0, 4, 0, 1'b0);
        idle(6);
        chk("post_rst_count", 32'(n_seen - seen0), 32'd2);
        chk("post_rst_pix", 32'(last_pix), 32'h0432);
        chk("post_rst_h", 32'(last_h), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
